// File: rtl/data_memory_decoder.sv
// Data-bus decoder and strobe sequencer for SRAM banks and peripherals.
// Ports: clk, nRESET, address/read/write/req in; CE_n/OE_n/WE_n, selects, busy/ready/bus_err out.
module data_memory_decoder #(
  parameter int          N           = 32,
  parameter int          NUM_SRAM    = 2,
  parameter int unsigned SRAM_BASE   = 'h10000,
  parameter int unsigned SRAM_STRIDE = 'h04000,
  parameter int unsigned CTRL_UB     = 'h44E10,
  parameter int unsigned UART_UB     = 'h48022,
  parameter int unsigned WAIT_SRAM   = 2,
  parameter int unsigned WAIT_PERIPH = 1
) (
  input  logic                clk,
  input  logic                nRESET,
  input  logic [N-1:0]        address,
  input  logic                read,
  input  logic                write,
  input  logic                req,
  output logic [NUM_SRAM-1:0] CE_n,
  output logic [NUM_SRAM-1:0] OE_n,
  output logic [NUM_SRAM-1:0] WE_n,
  output logic                CTRL_SEL_n,
  output logic                UART_SEL_n,
  output logic                busy,
  output logic                ready,
  output logic                bus_err
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, ERR
  } state_t;

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [NUM_SRAM-1:0] bank, bank_nx;
  logic ctrl, ctrl_nx;
  logic uart, uart_nx;
  logic rd, rd_nx;

  logic [N-13:0] ub;
  logic [NUM_SRAM-1:0] hit;
  logic hit_c, hit_u, found;
  logic unused_lo;

  assign ub = address[N-1:12];
  assign unused_lo = ^address[11:0];

  // Lowest bank wins, then control module, then UART.
  always_comb begin
    hit   = '0;
    hit_c = 1'b0;
    hit_u = 1'b0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRAM; i++) begin
      if (!found &&
          ub == (N-12)'(SRAM_BASE + i * SRAM_STRIDE)) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
    if (!found) begin
      if (ub == (N-12)'(CTRL_UB))
        hit_c = 1'b1;
      else if (ub == (N-12)'(UART_UB))
        hit_u = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bank_nx  = bank;
    ctrl_nx  = ctrl;
    uart_nx  = uart;
    rd_nx    = rd;
    unique case (state)
      IDLE: begin
        if (req && (read || write)) begin
          if ((read && write) ||
              !(|hit || hit_c || hit_u)) begin
            state_nx = ERR;
          end else begin
            state_nx = SETUP;
            bank_nx  = hit;
            ctrl_nx  = hit_c;
            uart_nx  = hit_u;
            rd_nx    = read;
          end
        end
      end
      SETUP: begin
        state_nx = STROBE;
        cnt_nx   = |bank ? 4'(WAIT_SRAM)
                         : 4'(WAIT_PERIPH);
      end
      STROBE: begin
        if (cnt == 4'd0)
          state_nx = HOLD;
        else
          cnt_nx = cnt - 4'd1;
      end
      HOLD:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they register with it.
  logic [NUM_SRAM-1:0] ce_nx, oe_nx, we_nx;
  logic cs_nx, us_nx, busy_nx, rdy_nx, err_nx;

  always_comb begin
    ce_nx   = '1;
    oe_nx   = '1;
    we_nx   = '1;
    cs_nx   = 1'b1;
    us_nx   = 1'b1;
    busy_nx = 1'b0;
    rdy_nx  = 1'b0;
    err_nx  = 1'b0;
    unique case (state_nx)
      SETUP, STROBE, HOLD: begin
        ce_nx   = ~bank_nx;
        cs_nx   = ~ctrl_nx;
        us_nx   = ~uart_nx;
        busy_nx = 1'b1;
        if (state_nx == STROBE) begin
          if (rd_nx)
            oe_nx = ~bank_nx;
          else
            we_nx = ~bank_nx;
        end
        if (state_nx == HOLD)
          rdy_nx = 1'b1;
      end
      ERR: begin
        busy_nx = 1'b1;
        rdy_nx  = 1'b1;
        err_nx  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      bank       <= '0;
      ctrl       <= 1'b0;
      uart       <= 1'b0;
      rd         <= 1'b0;
      CE_n       <= '1;
      OE_n       <= '1;
      WE_n       <= '1;
      CTRL_SEL_n <= 1'b1;
      UART_SEL_n <= 1'b1;
      busy       <= 1'b0;
      ready      <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      bank       <= bank_nx;
      ctrl       <= ctrl_nx;
      uart       <= uart_nx;
      rd         <= rd_nx;
      CE_n       <= ce_nx;
      OE_n       <= oe_nx;
      WE_n       <= we_nx;
      CTRL_SEL_n <= cs_nx;
      UART_SEL_n <= us_nx;
      busy       <= busy_nx;
      ready      <= rdy_nx;
      bus_err    <= err_nx;
    end
  end

endmodule

// File: tb/tb_data_memory_decoder.sv
// Randomized bench for data_memory_decoder with a transaction-level model.
// Directed accesses pin the model with literal cycle masks.
module tb_data_memory_decoder;

  localparam int N  = 32;
  localparam int NS = 2;
  localparam int unsigned BASE   = 'h10000;
  localparam int unsigned STRIDE = 'h04000;
  localparam int unsigned CUB    = 'h44E10;
  localparam int unsigned UUB    = 'h48022;
  localparam int WS = 2;
  localparam int WP = 1;

  logic clk = 1'b0;
  logic nRESET;
  logic [N-1:0] address;
  logic read, write, req;
  logic [NS-1:0] CE_n, OE_n, WE_n;
  logic CTRL_SEL_n, UART_SEL_n, busy, ready, bus_err;

  always #5 clk = ~clk;

  data_memory_decoder #(
    .N(N), .NUM_SRAM(NS),
    .SRAM_BASE(BASE), .SRAM_STRIDE(STRIDE),
    .CTRL_UB(CUB), .UART_UB(UUB),
    .WAIT_SRAM(WS), .WAIT_PERIPH(WP)
  ) dut (
    .clk(clk), .nRESET(nRESET),
    .address(address), .read(read),
    .write(write), .req(req),
    .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n),
    .CTRL_SEL_n(CTRL_SEL_n),
    .UART_SEL_n(UART_SEL_n),
    .busy(busy), .ready(ready),
    .bus_err(bus_err)
  );

  typedef struct packed {
    logic [NS-1:0] ce, oe, we;
    logic cs, us, busy, rdy, err;
  } ob_t;

  localparam ob_t IDLE_O = '{ce: '1, oe: '1, we: '1,
    cs: 1'b1, us: 1'b1, busy: 1'b0, rdy: 1'b0, err: 1'b0};

  ob_t q[$];
  ob_t seen[$];
  ob_t cur = IDLE_O;
  logic pe = 1'b0;
  int checks = 0;
  int errors = 0;

  function automatic ob_t dut_o();
    return {CE_n, OE_n, WE_n, CTRL_SEL_n,
            UART_SEL_n, busy, ready, bus_err};
  endfunction

  task automatic chk(string nm, ob_t got, ob_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic chkv(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask

  // Expected output sequence for one accepted request.
  function automatic void accept(logic [N-1:0] a,
                                 logic rd, logic wr);
    int tgt;
    logic [N-13:0] u;
    ob_t o, s;
    int w;
    tgt = -1;
    u = a[N-1:12];
    if (u == (N-12)'(UUB)) tgt = 101;
    if (u == (N-12)'(CUB)) tgt = 100;
    for (int i = NS - 1; i >= 0; i--)
      if (u == (N-12)'(BASE + i * STRIDE)) tgt = i;
    o = IDLE_O;
    if ((rd && wr) || tgt < 0) begin
      o.busy = 1'b1; o.rdy = 1'b1; o.err = 1'b1;
      q.push_back(o);
      return;
    end
    w = (tgt < NS) ? WS : WP;
    o.busy = 1'b1;
    if (tgt < NS) o.ce[tgt] = 1'b0;
    else if (tgt == 100) o.cs = 1'b0;
    else o.us = 1'b0;
    q.push_back(o);
    s = o;
    if (tgt < NS) begin
      if (rd) s.oe[tgt] = 1'b0;
      else s.we[tgt] = 1'b0;
    end
    repeat (w + 1) q.push_back(s);
    o.rdy = 1'b1;
    q.push_back(o);
  endfunction

  task automatic step(logic r, logic [N-1:0] a,
                      logic rd, logic wr, string nm);
    @(negedge clk);
    chk(nm, dut_o(), cur);
    seen.push_back(dut_o());
    req = r; address = a; read = rd; write = wr;
    @(posedge clk);
    if (nRESET) begin
      pe = cur.err;
      if (!cur.busy && q.size() == 0 && r && (rd || wr))
        accept(a, rd, wr);
      cur = (q.size() != 0) ? q.pop_front() : IDLE_O;
    end
  endtask

  task automatic analyze(logic [NS-1:0] pat,
      output int cm, output int om, output int wm,
      output int sm, output int rm, output int em,
      output int am);
    cm = 0; om = 0; wm = 0; sm = 0;
    rm = 0; em = 0; am = 0;
    for (int j = 0; j < seen.size() && j < 16; j++) begin
      if (seen[j].ce == pat) cm |= 1 << j;
      if (seen[j].oe == pat) om |= 1 << j;
      if (seen[j].we == pat) wm |= 1 << j;
      if (!seen[j].cs || !seen[j].us) sm |= 1 << j;
      if (seen[j].rdy) rm |= 1 << j;
      if (seen[j].err) em |= 1 << j;
      if (!(&seen[j].ce) || !(&seen[j].oe) ||
          !(&seen[j].we)) am |= 1 << j;
    end
  endtask

  task automatic directed(logic [N-1:0] a,
                          logic rd, logic wr);
    seen.delete();
    step(1'b1, a, rd, wr, "dir");
    repeat (7) step(1'b0, a, rd, wr, "dir");
  endtask

  function automatic logic [N-1:0] pick();
    logic [N-1:0] a;
    a = $urandom;
    case ($urandom_range(5, 0))
      0: a[N-1:12] = 20'h10000;
      1: a[N-1:12] = 20'h14000;
      2: a[N-1:12] = 20'h44E10;
      3: a[N-1:12] = 20'h48022;
      4: a[N-1:12] = 20'h18000;
      default: ;
    endcase
    return a;
  endfunction

  task automatic rst_pulse();
    @(negedge clk);
    #2 nRESET = 1'b0;
    #1 chk("rst_async", dut_o(), IDLE_O);
    q.delete();
    cur = IDLE_O;
    pe = 1'b0;
    repeat (2) step(1'($urandom), pick(),
                    1'($urandom), 1'($urandom), "rst_hold");
    #2 nRESET = 1'b1;
  endtask

  int cm, om, wm, sm, rm, em, am;

  initial begin
    nRESET = 1'b0;
    req = 1'b0; read = 1'b0; write = 1'b0;
    address = '0;
    repeat (3) step(1'($urandom), pick(),
                    1'($urandom), 1'($urandom), "reset");
    #2 nRESET = 1'b1;
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, "idle");

    directed(32'h1000_0040, 1'b1, 1'b0);
    analyze(2'b10, cm, om, wm, sm, rm, em, am);
    chkv("rd_ce", cm, 'h3E);
    chkv("rd_oe", om, 'h1C);
    chkv("rd_we", wm, 0);
    chkv("rd_ready", rm, 'h20);

    directed(32'h1400_0008, 1'b0, 1'b1);
    analyze(2'b01, cm, om, wm, sm, rm, em, am);
    chkv("wr_ce", cm, 'h3E);
    chkv("wr_we", wm, 'h1C);
    chkv("wr_oe", om, 0);

    directed(32'h4802_2000, 1'b0, 1'b1);
    analyze(2'b10, cm, om, wm, sm, rm, em, am);
    chkv("uart_sel", sm, 'h1E);
    chkv("uart_ready", rm, 'h10);
    chkv("uart_mem", am, 0);

    directed(32'h3000_0000, 1'b1, 1'b0);
    analyze(2'b10, cm, om, wm, sm, rm, em, am);
    chkv("unm_err", em, 'h02);
    chkv("unm_ready", rm, 'h02);
    chkv("unm_sel", sm | am, 0);

    directed(32'h1000_0000, 1'b1, 1'b1);
    analyze(2'b10, cm, om, wm, sm, rm, em, am);
    chkv("rw_err", em, 'h02);
    chkv("rw_ready", rm, 'h02);
    chkv("rw_sel", sm | am, 0);

    seen.delete();
    step(1'b1, 32'h1000_0040, 1'b1, 1'b0, "mr");
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, "mr");
    @(negedge clk);
    chkv("mr_strobe", int'(OE_n[0]), 0);
    #2 nRESET = 1'b0;
    #1;
    chkv("mr_oe0", int'(OE_n[0]), 1);
    chkv("mr_ce0", int'(CE_n[0]), 1);
    chk("mr_idle", dut_o(), IDLE_O);
    q.delete();
    cur = IDLE_O;
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, "mr_rst");
    #2 nRESET = 1'b1;
    repeat (5) step(1'b0, '0, 1'b0, 1'b0, "mr_after");
    analyze(2'b10, cm, om, wm, sm, rm, em, am);
    chkv("mr_noready", rm, 0);

    directed(32'h1400_0100, 1'b1, 1'b0);
    analyze(2'b01, cm, om, wm, sm, rm, em, am);
    chkv("b1_ce", cm, 'h3E);
    chkv("b1_oe", om, 'h1C);
    chkv("b1_ready", rm, 'h20);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(249, 0) == 0) begin
        rst_pulse();
      end else begin
        logic r;
        r = ($urandom_range(2, 0) == 0);
        if (cur.err || pe) r = 1'b0;
        step(r, pick(), 1'($urandom),
             1'($urandom), "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
